// File: rtl/mod_n_counter.sv
// ---------------------------------------------------------------------------
// mod_n_counter
//
// Free-running modulo-N up/down counter. The count moves by one on every
// rising clock edge. The direction is chosen on each edge by up_down. The
// count wraps within 0..N-1. The terminal-count flag tc goes high when the
// next step wraps. This lets several counters be cascaded.
//
// Parameters
//   N : modulus; count ranges over 0..N-1 (N >= 2)
//   W : width of count; 2**W must be >= N
//
// Ports
//   clk     : rising-edge clock, the only clock
//   reset   : synchronous active-low reset (0 clears count on the edge)
//   up_down : 1 = count up, 0 = count down; sampled on every edge
//   count   : registered count value, W bits
//   tc      : combinational terminal count; 1 when the next step wraps
// ---------------------------------------------------------------------------
module mod_n_counter #(
    parameter int N = 10,
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         up_down,
    output logic [W-1:0] count,
    output logic         tc
);

    // Reject impossible configurations during elaboration. The width check
    // is done at 64 bits, so a large W cannot overflow the shift.
    generate
        if (N < 2) begin : g_bad_modulus
            $fatal(1, "mod_n_counter: N (%0d) must be at least 2", N);
        end
        if ((64'd1 << W) < 64'(N)) begin : g_bad_width
            $fatal(1, "mod_n_counter: W (%0d) too narrow for N (%0d)", W, N);
        end
    endgenerate

    // The wrap points are explicit constants. The count therefore wraps at
    // N-1 instead of at the natural binary overflow, which matters whenever
    // N is not a power of two.
    localparam logic [W-1:0] LP_MAX = W'(N - 1);
    localparam logic [W-1:0] LP_MIN = '0;
    localparam logic [W-1:0] LP_ONE = W'(1);

    logic [W-1:0] r_count;
    logic [W-1:0] w_count_next;
    logic         w_at_max;
    logic         w_at_min;

    assign w_at_max = (r_count == LP_MAX);
    assign w_at_min = (r_count == LP_MIN);

    // Next-state selection. Direction is taken directly from this cycle's
    // up_down, so a reversal takes effect on the very next edge. No value is
    // repeated or skipped.
    always_comb begin
        w_count_next = r_count;
        if (up_down) begin
            w_count_next = w_at_max ? LP_MIN : (r_count + LP_ONE);
        end else begin
            w_count_next = w_at_min ? LP_MAX : (r_count - LP_ONE);
        end
    end

    // Count register. Reset has priority over counting, whatever up_down is.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_next;
        end
    end

    assign count = r_count;

    // tc looks one step ahead: it is high when the coming edge wraps in the
    // currently selected direction.
    assign tc = (up_down & w_at_max) | (~up_down & w_at_min);

endmodule

// File: tb/tb_mod_n_counter.sv
// ---------------------------------------------------------------------------
// tb_mod_n_counter
//
// Drives three counters (N=10/W=4, N=5/W=3, N=16/W=4) from a shared reset
// and direction. Each one is compared against a modular-arithmetic reference
// count. Inputs change on the falling edge. tc is checked after inputs
// settle, and count is checked just after each rising edge.
// ---------------------------------------------------------------------------
module tb_mod_n_counter;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       up_down = 1'b1;
    logic [3:0] count_a;
    logic [2:0] count_b;
    logic [3:0] count_c;
    logic       tc_a, tc_b, tc_c;

    always #5 clk = ~clk;

    mod_n_counter #(.N(10), .W(4)) u_dut_a (
        .clk(clk), .reset(reset), .up_down(up_down), .count(count_a), .tc(tc_a)
    );
    mod_n_counter #(.N(5), .W(3)) u_dut_b (
        .clk(clk), .reset(reset), .up_down(up_down), .count(count_b), .tc(tc_b)
    );
    mod_n_counter #(.N(16), .W(4)) u_dut_c (
        .clk(clk), .reset(reset), .up_down(up_down), .count(count_c), .tc(tc_c)
    );

    int n_checks = 0;
    int n_fail = 0;
    int modulus [3] = '{10, 5, 16};
    int model [3] = '{0, 0, 0};
    bit model_valid = 1'b0;

    task automatic check(input string tag, input int idx, input int obs, input int exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s[N=%0d]: observed %0d expected %0d", tag, modulus[idx], obs, exp);
        end
    endtask

    function automatic int obs_count(input int idx);
        case (idx)
            0:       return int'(count_a);
            1:       return int'(count_b);
            default: return int'(count_c);
        endcase
    endfunction

    function automatic int obs_tc(input int idx);
        case (idx)
            0:       return int'(tc_a);
            1:       return int'(tc_b);
            default: return int'(tc_c);
        endcase
    endfunction

    // One clock cycle. Apply inputs at the falling edge and check tc for the
    // current count and the new direction. Then take the rising edge, step the
    // reference model, and check count.
    task automatic cycle(input logic rst_n, input logic dir);
        int exp_tc;
        @(negedge clk);
        reset   = rst_n;
        up_down = dir;
        #1;
        if (model_valid) begin
            for (int i = 0; i < 3; i++) begin
                // A wrap happens when stepping up lands back on 0, or when
                // stepping down starts from 0.
                exp_tc = dir ? int'(((model[i] + 1) % modulus[i]) == 0)
                             : int'(model[i] == 0);
                check("tc", i, obs_tc(i), exp_tc);
            end
        end
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            if (!rst_n)   model[i] = 0;
            else if (dir) model[i] = (model[i] + 1) % modulus[i];
            else          model[i] = (model[i] + modulus[i] - 1) % modulus[i];
        end
        model_valid = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("count", i, obs_count(i), model[i]);
            n_checks++;
            assert (obs_count(i) < modulus[i])
            else begin
                n_fail++;
                $error("FAIL range[N=%0d]: observed %0d required below %0d",
                       modulus[i], obs_count(i), modulus[i]);
            end
        end
        $display("cycle reset=%0b up_down=%0b -> counts %0d/%0d/%0d tc %0b%0b%0b",
                 rst_n, dir, count_a, count_b, count_c, tc_a, tc_b, tc_c);
    endtask

    initial begin
        // Reset held for two edges counting up, then one more with up_down=0.
        // That edge checks tc=1 while count=0.
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b0);

        // Up wrap: 12 edges from reset release.
        for (int k = 0; k < 12; k++) cycle(1'b1, 1'b1);

        // Down wrap from 0: 12 edges.
        cycle(1'b0, 1'b0);
        for (int k = 0; k < 12; k++) cycle(1'b1, 1'b0);

        // Direction change at 5: the sequence goes 5,4,3.
        cycle(1'b0, 1'b1);
        for (int k = 0; k < 5; k++) cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);

        // Mid-run reset at 7, then resume counting up.
        cycle(1'b0, 1'b1);
        for (int k = 0; k < 7; k++) cycle(1'b1, 1'b1);
        cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b1);

        // Randomized directions with occasional resets.
        for (int k = 0; k < 300; k++) begin
            cycle(($urandom_range(0, 15) != 0), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
